// File: rtl/store_sequencer.sv
// -----------------------------------------------------------------------------
// store_sequencer
//
// Converts a CPU store request of byte, half, word or doubleword size into write
// cycles for a data memory. That memory accepts only a full 64-bit word write or
// a single-byte write.
//
// An aligned doubleword goes out as one word write. Every other store goes out
// as one byte write per byte, lowest address first. Byte k of the store data is
// written to address req_addr+k.
//
// When ALLOW_MISALIGNED=0, a misaligned half, word or double is dropped. The
// sequencer then raises a one-cycle misalign pulse instead of writing anything.
//
// Parameters
//   ALLOW_MISALIGNED  1: split misaligned accesses into byte writes
//                     0: drop and flag misaligned accesses
//
// Ports
//   clk          clock; all state changes on posedge
//   reset        asynchronous active-high reset
//   req_valid    store request present
//   req_ready    high while idle; a request is taken when valid && ready
//   req_size     0=byte 1=half 2=word 3=double
//   req_addr     byte address of the store
//   req_wdata    store data, right-justified, little-endian
//   mem_addr     memory address (registered)
//   mem_data_in  memory write data (registered)
//   mem_word_we  64-bit write enable (registered)
//   mem_byte_we  byte write enable, data in mem_data_in[7:0] (registered)
//   done         one-cycle pulse on the last write of a request
//   misalign     one-cycle pulse when a request is dropped
// -----------------------------------------------------------------------------
module store_sequencer #(
    parameter bit ALLOW_MISALIGNED = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_data_in,
    output logic        mem_word_we,
    output logic        mem_byte_we,
    output logic        done,
    output logic        misalign
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    // Write cycles still to be shown, counting the one on the outputs now.
    logic [3:0]  cnt_q, cnt_d;
    // Address and data of the next byte to be written.
    logic [63:0] addr_q, addr_d;
    logic [63:0] data_q, data_d;

    // Output registers. They stay stable across the memory's negedge write.
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_data_q, mem_data_d;
    logic        word_we_q, word_we_d;
    logic        byte_we_q, byte_we_d;
    logic        done_q, done_d;
    logic        misalign_q, misalign_d;

    logic [3:0]  req_len;
    logic [63:0] low_mask;
    logic        aligned;

    assign req_len  = 4'd1 << req_size;
    assign low_mask = {60'd0, req_len} - 64'd1;
    assign aligned  = (req_addr & low_mask) == 64'd0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mem_addr_d = 64'd0;
        mem_data_d = 64'd0;
        word_we_d  = 1'b0;
        byte_we_d  = 1'b0;
        done_d     = 1'b0;
        misalign_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!aligned && !ALLOW_MISALIGNED) begin
                        state_d    = ST_DROP;
                        misalign_d = 1'b1;
                    end else if (aligned && (req_size == 2'd3)) begin
                        // Single full-word write; done in the same cycle.
                        state_d    = ST_WRITE;
                        cnt_d      = 4'd1;
                        word_we_d  = 1'b1;
                        mem_addr_d = req_addr;
                        mem_data_d = req_wdata;
                        done_d     = 1'b1;
                    end else begin
                        // The first byte goes straight to the output registers.
                        // addr_q and data_q are set up for the byte after it.
                        state_d    = ST_WRITE;
                        cnt_d      = req_len;
                        byte_we_d  = 1'b1;
                        mem_addr_d = req_addr;
                        mem_data_d = {56'd0, req_wdata[7:0]};
                        done_d     = (req_len == 4'd1);
                        addr_d     = req_addr + 64'd1;
                        data_d     = req_wdata >> 8;
                    end
                end
            end
            ST_WRITE: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d      = cnt_q - 4'd1;
                    byte_we_d  = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = {56'd0, data_q[7:0]};
                    done_d     = (cnt_q == 4'd2);
                    addr_d     = addr_q + 64'd1;
                    data_d     = data_q >> 8;
                end
            end
            ST_DROP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 64'd0;
            data_q     <= 64'd0;
            mem_addr_q <= 64'd0;
            mem_data_q <= 64'd0;
            word_we_q  <= 1'b0;
            byte_we_q  <= 1'b0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            word_we_q  <= word_we_d;
            byte_we_q  <= byte_we_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_q;
    assign mem_word_we = word_we_q;
    assign mem_byte_we = byte_we_q;
    assign done        = done_q;
    assign misalign    = misalign_q;

endmodule
